// File: rtl/warp_xseqdiv_pkg.sv
// Shared definitions for the sequential divider: FSM state encodings and
// the fixed results returned for divide-by-zero and signed overflow.
package warp_defines;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PREP   = 3'd1,
    ST_DIVIDE = 3'd2,
    ST_FIXUP  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int CNT_W = 7;

  localparam logic [63:0] DIV0_QUOTIENT = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] OVF_REMAINDER = 64'h0000_0000_0000_0000;
  localparam logic [31:0] WORD_MIN      = 32'h8000_0000;

endpackage

// File: rtl/warp_xdiv_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the result if it fits.
module warp_xdiv_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] diff_s;
  logic          qbit_s;

  // Trial subtract; a clear borrow bit means the divisor fits.
  always_comb begin
    shifted_s = {rem_in, quo_in[XLEN-1]};
    diff_s    = shifted_s - {1'b0, divisor};
    if (!diff_s[XLEN]) begin
      rem_out = diff_s[XLEN-1:0];
      qbit_s  = 1'b1;
    end else begin
      rem_out = shifted_s[XLEN-1:0];
      qbit_s  = 1'b0;
    end
    quo_out = {quo_in[XLEN-2:0], qbit_s};
  end

endmodule

// File: rtl/warp_xseqdiv.sv
// Multi-cycle signed/unsigned divider (RISC-V div/divu/rem/remu and word
// forms) with kill support; BPC quotient bits are retired per DIVIDE cycle.
module warp_xseqdiv
  import warp_defines::*;
#(
  parameter int XLEN = 64,
  parameter int BPC  = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_input_valid,
  output logic            o_input_ready,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic [4:0]      i_rd,
  input  logic            i_unsigned,
  input  logic            i_word,
  input  logic            i_kill,
  output logic            o_valid,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder,
  output logic [4:0]      o_rd
);

  localparam logic [CNT_W-1:0] N_FULL = CNT_W'(XLEN / BPC - 1);
  localparam logic [CNT_W-1:0] N_WORD = CNT_W'(32 / BPC - 1);
  localparam logic [XLEN-1:0]  XMIN   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ONES   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  ZERO   = {XLEN{1'b0}};

  state_t            state_r, next_s;
  logic [XLEN-1:0]   op1_r, op2_r, dvs_r, rem_r, quo_r;
  logic [XLEN-1:0]   quot_r, remd_r;
  logic [4:0]        rd_r, ord_r;
  logic              uns_r, word_r, q_neg_r, r_neg_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [XLEN-1:0]   a_ext_s, b_ext_s, a_abs_s, b_abs_s;
  logic [XLEN-1:0]   res_q_s, res_r_s, out_q_s, out_r_s;
  logic              a_neg_s, b_neg_s, div0_s, ovf_s, special_s;

  logic [XLEN-1:0]   rem_c_s [BPC+1];
  logic [XLEN-1:0]   quo_c_s [BPC+1];

  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
    logic [XLEN-1:0] e;
    e       = {XLEN{sgn & v[31]}};
    e[31:0] = v;
    return e;
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Operand conditioning, special-case detection and result selection.
  always_comb begin
    a_ext_s   = word_r ? ext32(op1_r[31:0], ~uns_r) : op1_r;
    b_ext_s   = word_r ? ext32(op2_r[31:0], ~uns_r) : op2_r;
    a_neg_s   = ~uns_r & a_ext_s[XLEN-1];
    b_neg_s   = ~uns_r & b_ext_s[XLEN-1];
    a_abs_s   = neg_if(a_ext_s, a_neg_s);
    b_abs_s   = neg_if(b_ext_s, b_neg_s);
    div0_s    = (b_ext_s == ZERO);
    ovf_s     = ~uns_r & (b_ext_s == ONES) &
                (a_ext_s == (word_r ? ext32(WORD_MIN, 1'b1) : XMIN));
    special_s = div0_s | ovf_s;
    if (state_r == ST_PREP) begin
      res_q_s = div0_s ? DIV0_QUOTIENT[XLEN-1:0] : a_ext_s;
      res_r_s = div0_s ? a_ext_s : OVF_REMAINDER[XLEN-1:0];
    end else begin
      res_q_s = neg_if(quo_r, q_neg_r);
      res_r_s = neg_if(rem_r, r_neg_r);
    end
    out_q_s = word_r ? ext32(res_q_s[31:0], 1'b1) : res_q_s;
    out_r_s = word_r ? ext32(res_r_s[31:0], 1'b1) : res_r_s;
  end

  assign rem_c_s[0] = rem_r;
  assign quo_c_s[0] = quo_r;

  for (genvar g = 0; g < BPC; g++) begin : g_step
    warp_xdiv_step #(.XLEN(XLEN)) u_step (
      .rem_in  (rem_c_s[g]),
      .quo_in  (quo_c_s[g]),
      .divisor (dvs_r),
      .rem_out (rem_c_s[g+1]),
      .quo_out (quo_c_s[g+1])
    );
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_r <= ST_IDLE;
    else       state_r <= next_s;
  end

  // FSM next state; kill wins over every advance outside IDLE.
  always_comb begin
    next_s = ST_IDLE;
    case (state_r)
      ST_IDLE:   next_s = i_input_valid ? ST_PREP : ST_IDLE;
      ST_PREP:   next_s = i_kill ? ST_IDLE : (special_s ? ST_DONE : ST_DIVIDE);
      ST_DIVIDE: next_s = i_kill ? ST_IDLE : ((cnt_r == {CNT_W{1'b0}}) ? ST_FIXUP : ST_DIVIDE);
      ST_FIXUP:  next_s = i_kill ? ST_IDLE : ST_DONE;
      ST_DONE:   next_s = ST_IDLE;
      default:   next_s = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_input_ready = (state_r == ST_IDLE);
    o_valid       = (state_r == ST_DONE) & ~i_kill;
  end

  // Operand capture and iterative datapath.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op1_r   <= ZERO;
      op2_r   <= ZERO;
      rd_r    <= 5'd0;
      uns_r   <= 1'b0;
      word_r  <= 1'b0;
      dvs_r   <= ZERO;
      rem_r   <= ZERO;
      quo_r   <= ZERO;
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_input_valid) begin
            op1_r  <= i_op1;
            op2_r  <= i_op2;
            rd_r   <= i_rd;
            uns_r  <= i_unsigned;
            word_r <= (XLEN == 64) ? i_word : 1'b0;
          end
        end
        ST_PREP: begin
          cnt_r   <= word_r ? N_WORD : N_FULL;
          rem_r   <= ZERO;
          // Word mode starts the dividend at bit 31 so only 32 bits are walked.
          quo_r   <= word_r ? (a_abs_s << 6'd32) : a_abs_s;
          dvs_r   <= b_abs_s;
          q_neg_r <= a_neg_s ^ b_neg_s;
          r_neg_r <= a_neg_s;
        end
        ST_DIVIDE: begin
          rem_r <= rem_c_s[BPC];
          quo_r <= quo_c_s[BPC];
          cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers load only on entry to DONE and hold otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      quot_r <= ZERO;
      remd_r <= ZERO;
      ord_r  <= 5'd0;
    end else if ((next_s == ST_DONE) && (state_r != ST_DONE)) begin
      quot_r <= out_q_s;
      remd_r <= out_r_s;
      ord_r  <= rd_r;
    end
  end

  assign o_quotient  = quot_r;
  assign o_remainder = remd_r;
  assign o_rd        = ord_r;

endmodule

// File: tb/tb_warp_xseqdiv.sv
// Scoreboard bench: unit 0 is XLEN=64/BPC=1, unit 1 is XLEN=64/BPC=2;
// expected results come from a RISC-V division reference model.
module tb_warp_xseqdiv;

  typedef struct {
    int          unit;
    logic [63:0] q;
    logic [63:0] r;
    logic [4:0]  rd;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        vld   [2];
  logic        kill  [2];
  logic        uns   [2];
  logic        word  [2];
  logic [63:0] op1   [2];
  logic [63:0] op2   [2];
  logic [4:0]  rd    [2];
  logic        rdy   [2];
  logic        ov    [2];
  logic [63:0] oq    [2];
  logic [63:0] orm   [2];
  logic [4:0]  ord   [2];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  warp_xseqdiv #(.XLEN(64), .BPC(1)) u0 (
    .i_clk(clk), .i_rst(rst[0]), .i_input_valid(vld[0]), .o_input_ready(rdy[0]),
    .i_op1(op1[0]), .i_op2(op2[0]), .i_rd(rd[0]), .i_unsigned(uns[0]),
    .i_word(word[0]), .i_kill(kill[0]), .o_valid(ov[0]), .o_quotient(oq[0]),
    .o_remainder(orm[0]), .o_rd(ord[0])
  );

  warp_xseqdiv #(.XLEN(64), .BPC(2)) u1 (
    .i_clk(clk), .i_rst(rst[1]), .i_input_valid(vld[1]), .o_input_ready(rdy[1]),
    .i_op1(op1[1]), .i_op2(op2[1]), .i_rd(rd[1]), .i_unsigned(uns[1]),
    .i_word(word[1]), .i_kill(kill[1]), .o_valid(ov[1]), .o_quotient(oq[1]),
    .o_remainder(orm[1]), .o_rd(ord[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // RISC-V division semantics, computed directly with SV arithmetic.
  function automatic void ref_div(input logic [63:0] a, input logic [63:0] b,
                                  input logic un, input logic wd,
                                  output logic [63:0] q, output logic [63:0] r);
    logic [31:0] a32, b32, q32, r32;
    a32 = a[31:0];
    b32 = b[31:0];
    if (wd) begin
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32;
      end else if (!un && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0;
      end else if (un) begin
        q32 = a32 / b32; r32 = a32 % b32;
      end else begin
        q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) begin
        q = 64'hFFFF_FFFF_FFFF_FFFF; r = a;
      end else if (!un && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        q = a; r = 64'd0;
      end else if (un) begin
        q = a / b; r = a % b;
      end else begin
        q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
      end
    end
  endfunction

  task automatic issue(input int u, input logic [63:0] a, input logic [63:0] b,
                       input logic un, input logic wd, input logic [4:0] r_d,
                       input logic push, input logic [63:0] eq, input logic [63:0] er);
    exp_t e;
    logic spec;
    @(negedge clk);
    chk("input_ready_idle", 64'(rdy[u]), 64'd1);
    vld[u] = 1'b1; op1[u] = a; op2[u] = b; uns[u] = un; word[u] = wd; rd[u] = r_d;
    @(posedge clk);
    #1;
    vld[u] = 1'b0;
    op1[u] = {$urandom, $urandom};
    op2[u] = {$urandom, $urandom};
    if (push) begin
      spec = wd ? (b[31:0] == 32'd0 || (!un && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF))
                : (b == 64'd0 || (!un && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
      e.unit = u; e.q = eq; e.r = er; e.rd = r_d; e.acc = cyc;
      e.lat  = spec ? 2 : ((wd ? 32 : 64) / (u == 0 ? 1 : 2)) + 3;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && sbq.size() != 0; i++) @(posedge clk);
    chk("result_timeout_pending", 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  task automatic run(input int u, input logic [63:0] a, input logic [63:0] b,
                     input logic un, input logic wd, input logic [4:0] r_d,
                     input logic [63:0] eq, input logic [63:0] er);
    issue(u, a, b, un, wd, r_d, 1'b1, eq, er);
    wait_done();
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(1, 50));
      4: return {{32{1'b1}}, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic rnd_op(input int u);
    logic [63:0] a, b, q, r;
    logic un, wd;
    a  = pick();
    b  = pick();
    un = 1'($urandom);
    wd = 1'($urandom);
    if ($urandom_range(0, 3) == 0) a[31:0] = 32'h8000_0000;
    ref_div(a, b, un, wd, q, r);
    run(u, a, b, un, wd, 5'($urandom), q, r);
  endtask

  task automatic chk_reset(input int u);
    chk("rst_ready", 64'(rdy[u]), 64'd1);
    chk("rst_valid", 64'(ov[u]), 64'd0);
    chk("rst_quotient", oq[u], 64'd0);
    chk("rst_remainder", orm[u], 64'd0);
    chk("rst_rd", 64'(ord[u]), 64'd0);
  endtask

  // Monitor: every o_valid strobe must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    for (int u = 0; u < 2; u++) begin
      if (ov[u]) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_valid: unit %0d got o_valid=1 want 0", u);
        end else begin
          e = sbq.pop_front();
          chk("unit", 64'(u), 64'(e.unit));
          chk("quotient", oq[u], e.q);
          chk("remainder", orm[u], e.r);
          chk("rd", 64'(ord[u]), 64'(e.rd));
          chk("latency", 64'(cyc + 1 - e.acc), 64'(e.lat));
        end
      end
    end
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; vld[u] = 1'b0; kill[u] = 1'b0; uns[u] = 1'b0; word[u] = 1'b0;
      op1[u] = 64'd0; op2[u] = 64'd0; rd[u] = 5'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    run(0, 64'd100, 64'd7, 1'b1, 1'b0, 5'd9, 64'd14, 64'd2);
    run(0, -64'sd7, 64'd2, 1'b0, 1'b0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
    run(0, 64'd7, -64'sd2, 1'b0, 1'b0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1);
    run(0, 64'd5, 64'd0, 1'b0, 1'b0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5);
    run(0, 64'd5, 64'd0, 1'b1, 1'b0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5);
    run(0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 5'd7,
        64'hFFFF_FFFF_8000_0000, 64'd0);
    run(0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 5'd8,
        64'h8000_0000_0000_0000, 64'd0);

    // Kill at cycle 20 of a full-width divide.
    issue(0, 64'd12345, 64'd17, 1'b1, 1'b0, 5'd11, 1'b0, 64'd0, 64'd0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    kill[0] = 1'b1;
    @(posedge clk);
    #1;
    kill[0] = 1'b0;
    @(negedge clk);
    chk("kill_ready_cycle21", 64'(rdy[0]), 64'd1);
    repeat (80) @(posedge clk);
    run(0, 64'd100, 64'd7, 1'b1, 1'b0, 5'd12, 64'd14, 64'd2);

    // Kill while in PREP.
    issue(0, 64'd999, 64'd0, 1'b1, 1'b0, 5'd13, 1'b0, 64'd0, 64'd0);
    kill[0] = 1'b1;
    @(posedge clk);
    #1;
    kill[0] = 1'b0;
    chk("kill_prep_ready", 64'(rdy[0]), 64'd1);
    repeat (5) @(posedge clk);

    for (int i = 0; i < 30; i++) rnd_op(0);

    // Two-bit-per-cycle unit: reset pulsed mid-DIVIDE.
    run(1, 64'd77, 64'd5, 1'b1, 1'b0, 5'd21, 64'd15, 64'd2);
    issue(1, {$urandom, $urandom}, 64'd3, 1'b1, 1'b0, 5'd22, 1'b0, 64'd0, 64'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    chk_reset(1);
    rst[1] = 1'b0;
    repeat (60) @(posedge clk);
    run(1, 64'd1000, 64'd10, 1'b1, 1'b0, 5'd23, 64'd100, 64'd0);

    for (int i = 0; i < 20; i++) rnd_op(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
